// File: rtl/dff_pipe_pkg.sv
// Shared types and legality limits for the dff_pipe register pipeline.
// The stage record carries a parity bit only when DFF_PIPE_PARITY_EN is defined.
package dff_pipe_pkg;

  localparam int unsigned MinWidth = 1;
  localparam int unsigned MaxWidth = 64;
  localparam int unsigned MinDepth = 1;
  localparam int unsigned MaxDepth = 16;

  // Data is sized for the widest legal build; narrower builds leave the top bits at zero.
  typedef struct packed {
    logic                valid;
`ifdef DFF_PIPE_PARITY_EN
    logic                par;
`endif
    logic [MaxWidth-1:0] data;
  } stage_rec_t;

  function automatic bit cfg_legal(int unsigned width, int unsigned depth);
    return (width >= MinWidth) && (width <= MaxWidth) &&
           (depth >= MinDepth) && (depth <= MaxDepth);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: loads a full stage record when enabled, synchronous clear,
// asynchronous active-low reset.
module dff_stage
  import dff_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       clr,
  input  stage_rec_t d,
  output stage_rec_t q
);

  stage_rec_t rec_q;

  // clr wins over load so a flush always empties the stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rec_q <= '0;
    end else if (clr) begin
      rec_q <= '0;
    end else if (load) begin
      rec_q <= d;
    end
  end

  assign q = rec_q;

endmodule

// File: rtl/dff_pipe.sv
// Parameterised register pipeline with per-stage valid tags and a registered occupancy count.
// Defining DFF_PIPE_PARITY_EN adds per-stage even parity and the par_err output.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned USE_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           d,
  output logic [WIDTH-1:0]           q,
  output logic                       out_valid,
`ifdef DFF_PIPE_PARITY_EN
  output logic                       par_err,
`endif
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  if (!cfg_legal(WIDTH, DEPTH)) begin : gen_bad_cfg
    $error("dff_pipe: WIDTH must be 1..64 and DEPTH must be 1..16");
  end

  logic advance;
  assign advance = (USE_EN == 0) || en;

  stage_rec_t head;
  stage_rec_t tail;
  stage_rec_t stage_q [DEPTH];

  // Data is captured even for bubbles; in_valid only sets the tag.
  always_comb begin
    head                 = '0;
    head.valid           = in_valid;
    head.data[WIDTH-1:0] = d;
`ifdef DFF_PIPE_PARITY_EN
    head.par             = ^d;
`endif
  end

  for (genvar i = 0; i < DEPTH; i++) begin : gen_stage
    stage_rec_t src;
    if (i == 0) begin : gen_head
      assign src = head;
    end else begin : gen_chain
      assign src = stage_q[i-1];
    end

    dff_stage u_stage (
      .clk  (clk),
      .rst  (rst),
      .load (advance),
      .clr  (clr),
      .d    (src),
      .q    (stage_q[i])
    );
  end

  assign tail      = stage_q[DEPTH-1];
  assign q         = tail.data[WIDTH-1:0];
  assign out_valid = tail.valid;

  logic [MaxWidth-1:0] unused_tail_data;
  assign unused_tail_data = tail.data;

`ifdef DFF_PIPE_PARITY_EN
  assign par_err = tail.valid & ((^q) != tail.par);
`endif

  logic [OccW-1:0] occ_q, occ_d;

  // Tracks set tags incrementally: one may enter and one may leave per advance.
  always_comb begin
    occ_d = occ_q;
    if (clr) begin
      occ_d = '0;
    end else if (advance) begin
      case ({in_valid, tail.valid})
        2'b10:   occ_d = occ_q + OccW'(1);
        2'b01:   occ_d = occ_q - OccW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: directed table, hand sequences and random traffic
// checked against a queue-based model; two DUTs cover USE_EN=1 and USE_EN=0.
module tb_dff_pipe;
  import dff_pipe_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         en0, clr0, iv0, en1, clr1, iv1;
  logic [W-1:0] d0, d1, q0, q1;
  logic         ov0, ov1;
  logic [2:0]   occ0, occ1;
`ifdef DFF_PIPE_PARITY_EN
  logic         pe0, pe1;
  stage_rec_t   flip;
`endif

  dff_pipe #(.WIDTH(W), .DEPTH(D), .USE_EN(1)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .en        (en0),
    .clr       (clr0),
    .in_valid  (iv0),
    .d         (d0),
    .q         (q0),
    .out_valid (ov0),
`ifdef DFF_PIPE_PARITY_EN
    .par_err   (pe0),
`endif
    .occupancy (occ0)
  );

  dff_pipe #(.WIDTH(W), .DEPTH(D), .USE_EN(0)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .en        (en1),
    .clr       (clr1),
    .in_valid  (iv1),
    .d         (d1),
    .q         (q1),
    .out_valid (ov1),
`ifdef DFF_PIPE_PARITY_EN
    .par_err   (pe1),
`endif
    .occupancy (occ1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a queue always holding DEPTH entries, oldest at the front = output stage.
  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
  } ent_t;

  ent_t hist0[$];
  ent_t hist1[$];

  task automatic model_reset(input int k);
    if (k == 0) begin
      hist0.delete();
      for (int i = 0; i < D; i++) hist0.push_back('0);
    end else begin
      hist1.delete();
      for (int i = 0; i < D; i++) hist1.push_back('0);
    end
  endtask

  task automatic model_edge(input int k, input logic adv, input logic c, input logic iv,
                            input logic [W-1:0] dd);
    ent_t e;
    e.v = iv;
    e.d = dd;
    if (c) begin
      model_reset(k);
    end else if (adv) begin
      if (k == 0) begin
        hist0.push_back(e);
        void'(hist0.pop_front());
      end else begin
        hist1.push_back(e);
        void'(hist1.pop_front());
      end
    end
  endtask

  task automatic chk_model(input int k, input string tag);
    ent_t e;
    int   occ;
    occ = 0;
    if (k == 0) begin
      e = hist0[0];
      foreach (hist0[i]) occ += int'(hist0[i].v);
      chk({tag, "_q"}, 64'(q0), 64'(e.d));
      chk({tag, "_ov"}, 64'(ov0), 64'(e.v));
      chk({tag, "_occ"}, 64'(occ0), 64'(occ));
    end else begin
      e = hist1[0];
      foreach (hist1[i]) occ += int'(hist1[i].v);
      chk({tag, "_q"}, 64'(q1), 64'(e.d));
      chk({tag, "_ov"}, 64'(ov1), 64'(e.v));
      chk({tag, "_occ"}, 64'(occ1), 64'(occ));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_edge(0, en0, clr0, iv0, d0);
      model_edge(1, 1'b1, clr1, iv1, d1);
    end
    #1;
  endtask

  typedef struct {
    logic         en;
    logic         clr;
    logic         iv;
    logic [W-1:0] d;
    logic [W-1:0] eq;
    logic         eov;
    int           eocc;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'h11, 8'h00, 1'b0, 1};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h22, 8'h00, 1'b0, 2};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'h33, 8'h00, 1'b0, 3};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'h44, 8'h11, 1'b1, 4};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h55, 8'h22, 1'b1, 4};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h99, 8'h22, 1'b1, 4};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h99, 8'h22, 1'b1, 4};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h99, 8'h22, 1'b1, 4};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h66, 8'h33, 1'b1, 4};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h77, 8'h44, 1'b1, 3};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 8'hAA, 8'h00, 1'b0, 0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 8'hBB, 8'h00, 1'b0, 0};

    rst = 1'b0;
    {en0, clr0, iv0, en1, clr1, iv1} = '0;
    d0 = '0;
    d1 = '0;
    model_reset(0);
    model_reset(1);
    #1;
    chk("reset_q", 64'(q0), 64'h0);
    chk("reset_ov", 64'(ov0), 64'h0);
    chk("reset_occ", 64'(occ0), 64'h0);
    #11 rst = 1'b1;

    // Streaming, stall, flush priority on dut0; no-enable bubbles on dut1.
    for (int i = 0; i < 12; i++) begin
      en0  = tbl[i].en;
      clr0 = tbl[i].clr;
      iv0  = tbl[i].iv;
      d0   = tbl[i].d;
      en1  = 1'b0;
      clr1 = 1'b0;
      iv1  = (i % 2 == 0);
      d1   = W'(8'h10 + i);
      tick();
      chk($sformatf("tbl%0d_q", i), 64'(q0), 64'(tbl[i].eq));
      chk($sformatf("tbl%0d_ov", i), 64'(ov0), 64'(tbl[i].eov));
      chk($sformatf("tbl%0d_occ", i), 64'(occ0), 64'(tbl[i].eocc));
      if (i >= 3) begin
        chk($sformatf("noen%0d_q", i), 64'(q1), 64'(8'h10 + i - 3));
        chk($sformatf("noen%0d_ov", i), 64'(ov1), 64'((i - 3) % 2 == 0));
      end
      if (i >= 2) chk($sformatf("noen%0d_occ", i), 64'(occ1), 64'd2);
    end

    // Asynchronous reset mid-stream with three valid entries in flight.
    en0 = 1'b1;
    clr0 = 1'b0;
    iv0 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      d0 = W'(8'hC0 + i);
      tick();
    end
    iv0 = 1'b0;
    d0  = 8'hC5;
    tick();
    chk("pre_rst_q", 64'(q0), 64'hC2);
    chk("pre_rst_ov", 64'(ov0), 64'h1);
    chk("pre_rst_occ", 64'(occ0), 64'h3);
    #2 rst = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    chk("async_rst_q", 64'(q0), 64'h0);
    chk("async_rst_ov", 64'(ov0), 64'h0);
    chk("async_rst_occ", 64'(occ0), 64'h0);
    chk("async_rst_occ1", 64'(occ1), 64'h0);
    tick();
    chk("held_rst_occ", 64'(occ0), 64'h0);
    #3 rst = 1'b1;
    iv0 = 1'b1;
    d0  = 8'h5A;
    tick();
    chk("post_rst_occ", 64'(occ0), 64'h1);
    chk("post_rst_ov", 64'(ov0), 64'h0);
    chk_model(0, "post_rst");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en0  = ($urandom_range(0, 9) < 7);
      clr0 = ($urandom_range(0, 29) == 0);
      iv0  = 1'($urandom_range(0, 1));
      d0   = W'($urandom);
      en1  = 1'($urandom_range(0, 1));
      clr1 = ($urandom_range(0, 29) == 0);
      iv1  = 1'($urandom_range(0, 1));
      d1   = W'($urandom);
      tick();
      chk_model(0, $sformatf("rnd%0d_a", i));
      chk_model(1, $sformatf("rnd%0d_b", i));
`ifdef DFF_PIPE_PARITY_EN
      chk($sformatf("rnd%0d_pe0", i), 64'(pe0), 64'h0);
      chk($sformatf("rnd%0d_pe1", i), 64'(pe1), 64'h0);
`endif
    end

`ifdef DFF_PIPE_PARITY_EN
    // Injected single-bit flip in the output stage: flagged only for a valid entry.
    en0 = 1'b1;
    clr0 = 1'b0;
    iv0 = 1'b1;
    repeat (4) begin
      d0 = W'($urandom);
      tick();
    end
    chk("par_clean", 64'(pe0), 64'h0);
    flip = dut0.gen_stage[3].u_stage.rec_q;
    flip.data[0] = ~flip.data[0];
    force dut0.gen_stage[3].u_stage.rec_q = flip;
    #1;
    chk("par_err_valid", 64'(pe0), 64'h1);
    release dut0.gen_stage[3].u_stage.rec_q;
    iv0 = 1'b0;
    repeat (4) begin
      d0 = W'($urandom);
      tick();
    end
    chk("par_bubble_ov", 64'(ov0), 64'h0);
    flip = dut0.gen_stage[3].u_stage.rec_q;
    flip.data[0] = ~flip.data[0];
    force dut0.gen_stage[3].u_stage.rec_q = flip;
    #1;
    chk("par_err_bubble", 64'(pe0), 64'h0);
    release dut0.gen_stage[3].u_stage.rec_q;
    tick();
    chk_model(0, "par_after");
    chk("par_after_pe", 64'(pe0), 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
